// File: rtl/rtc_pkg.sv
// Shared types and constants for the DS1307-style time reader: FSM states,
// register pointer, read length, BCD limits and the 12h->24h BCD helper.
package rtc_pkg;

  typedef enum logic [2:0] {
    Idle,
    Request,
    WaitAccept,
    WaitDone,
    Decode
  } state_e;

  localparam logic [7:0] RtcRegPointer = 8'h00;
  localparam int         RtcReadBytes  = 3;

  localparam logic [3:0] BcdMaxDigit   = 4'd9;
  localparam logic [7:0] BcdMaxSecMin  = 8'h59;
  localparam logic [7:0] BcdMaxHour24  = 8'h23;
  localparam logic [7:0] BcdMaxHour12  = 8'h12;

  // BCD(h12 + 12) for a 12h field of 01..11; the result always lies in 13..23.
  function automatic logic [7:0] bcd_plus12(input logic [4:0] h12);
    logic [7:0] bin;
    bin = {4'd0, h12[3:0]} + (h12[4] ? 8'd22 : 8'd12);
    if (bin >= 8'd20) return {4'd2, 4'(bin - 8'd20)};
    else              return {4'd1, 4'(bin - 8'd10)};
  endfunction

endpackage

// File: rtl/rtc_time_reader_if.sv
// I2C master command/response bundle between the time reader and the I2C master.
// Handshake: i2cStart is a one-cycle request taken while i2cReady=1; the master
// acknowledges by dropping i2cReady, and its return to 1 marks completion, at
// which point i2cBytesRead and i2cClockStretchTimeout are valid.
interface rtc_time_reader_if;
  logic        i2cStart;
  logic [6:0]  i2cAddress;
  logic [7:0]  i2cNrOfBytesToSend;
  logic [7:0]  i2cByteToSend;
  logic [7:0]  i2cNrOfBytesToRead;
  logic [23:0] i2cBytesRead;
  logic        i2cReady;
  logic        i2cClockStretchTimeout;

  modport master (
    output i2cStart, i2cAddress, i2cNrOfBytesToSend, i2cByteToSend, i2cNrOfBytesToRead,
    input  i2cBytesRead, i2cReady, i2cClockStretchTimeout
  );

  modport slave (
    input  i2cStart, i2cAddress, i2cNrOfBytesToSend, i2cByteToSend, i2cNrOfBytesToRead,
    output i2cBytesRead, i2cReady, i2cClockStretchTimeout
  );
endinterface

// File: rtl/rtc_hours_normalizer.sv
// Converts a raw DS1307 hours register (12h or 24h mode) into 24h BCD and
// flags whether the raw field held a legal hour.
module rtc_hours_normalizer
  import rtc_pkg::*;
(
  input  logic [7:0] hours_raw_i,
  output logic [7:0] hours_bcd_o,
  output logic       hours_ok_o
);

  logic [7:0] h24;
  logic [7:0] h12;
  logic       pm;

  always_comb begin
    h24         = {2'b00, hours_raw_i[5:0]};
    h12         = {3'b000, hours_raw_i[4:0]};
    pm          = hours_raw_i[5];
    hours_bcd_o = h24;
    hours_ok_o  = (h24[3:0] <= BcdMaxDigit) && (h24 <= BcdMaxHour24);
    if (hours_raw_i[6]) begin
      hours_ok_o = (h12[3:0] <= BcdMaxDigit) && (h12 != 8'h00) && (h12 <= BcdMaxHour12);
      // 12 AM is midnight (00) and 12 PM is noon (12).
      if (h12 == BcdMaxHour12) hours_bcd_o = pm ? BcdMaxHour12 : 8'h00;
      else                     hours_bcd_o = pm ? bcd_plus12(h12[4:0]) : h12;
    end
  end

endmodule

// File: rtl/rtc_time_reader.sv
// Periodic RTC poller: writes pointer 0x00, reads seconds/minutes/hours over the
// I2C master, validates the BCD and publishes 24h time plus status flags.
module rtc_time_reader
  import rtc_pkg::*;
#(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned PollPeriodMs   = 250,
  parameter int unsigned ReadyTimeoutMs = 50,
  parameter logic [6:0]  RtcAddress     = 7'h68
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               readNow,
  rtc_time_reader_if.master  i2c,
  output logic [7:0]         secondsBcd,
  output logic [7:0]         minutesBcd,
  output logic [7:0]         hoursBcd,
  output logic               clockHalted,
  output logic               timeValid,
  output logic               updated,
  output logic               busy,
  output logic               errorTimeout,
  output logic               errorData,
  output state_e             stateDebug
);

  localparam int unsigned PollCycles = ClockFrequency / 1000 * PollPeriodMs;
  localparam int unsigned TmoCycles  = ClockFrequency / 1000 * ReadyTimeoutMs;
  localparam int          PollW      = $clog2(PollCycles + 1);
  localparam int          TmoW       = $clog2(TmoCycles + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(PollCycles - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TmoCycles - 1);

  state_e            state_q, state_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              pending_q, pending_d;
  logic [23:0]       bytes_q, bytes_d;
  logic [7:0]        sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic              ch_q, ch_d, valid_q, valid_d, upd_q, upd_d;
  logic              start_q, start_d, busy_q, busy_d;
  logic              err_tmo_q, err_tmo_d, err_data_q, err_data_d;

  logic              expire, tmo_hit, sec_ok, min_ok, hr_ok;
  logic [7:0]        sec_raw, min_raw, hr_norm;

  rtc_hours_normalizer u_hours (
    .hours_raw_i (bytes_q[23:16]),
    .hours_bcd_o (hr_norm),
    .hours_ok_o  (hr_ok)
  );

  assign sec_raw = {1'b0, bytes_q[6:0]};
  assign min_raw = {1'b0, bytes_q[14:8]};
  assign sec_ok  = (sec_raw[3:0] <= BcdMaxDigit) && (sec_raw <= BcdMaxSecMin);
  assign min_ok  = (min_raw[3:0] <= BcdMaxDigit) && (min_raw <= BcdMaxSecMin);
  assign expire  = (poll_cnt_q == PollLast);
  assign tmo_hit = (tmo_cnt_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = expire ? '0 : poll_cnt_q + 1'b1;
    pending_d  = pending_q | expire | readNow;
    tmo_cnt_d  = tmo_cnt_q;
    bytes_d    = bytes_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    ch_d       = ch_q;
    valid_d    = valid_q;
    upd_d      = 1'b0;
    err_tmo_d  = err_tmo_q;
    err_data_d = err_data_q;
    unique case (state_q)
      Idle: begin
        if (pending_q && i2c.i2cReady) begin
          // A request arriving in this same cycle stays queued for the next poll.
          pending_d  = expire | readNow;
          err_tmo_d  = 1'b0;
          err_data_d = 1'b0;
          state_d    = Request;
        end
      end
      Request: begin
        tmo_cnt_d = '0;
        state_d   = WaitAccept;
      end
      WaitAccept: begin
        if (!i2c.i2cReady) begin
          tmo_cnt_d = '0;
          state_d   = WaitDone;
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = Idle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WaitDone: begin
        if (i2c.i2cReady) begin
          if (i2c.i2cClockStretchTimeout) begin
            err_tmo_d = 1'b1;
            state_d   = Idle;
          end else begin
            bytes_d = i2c.i2cBytesRead;
            state_d = Decode;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = Idle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      Decode: begin
        if (sec_ok && min_ok && hr_ok) begin
          sec_d   = sec_raw;
          min_d   = min_raw;
          hr_d    = hr_norm;
          ch_d    = bytes_q[7];
          valid_d = 1'b1;
          upd_d   = 1'b1;
        end else begin
          err_data_d = 1'b1;
        end
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
    start_d = (state_d == Request);
    busy_d  = (state_d != Idle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= Idle;
      poll_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      pending_q  <= 1'b0;
      bytes_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      ch_q       <= 1'b0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pending_q  <= pending_d;
      bytes_q    <= bytes_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      err_tmo_q  <= err_tmo_d;
      err_data_q <= err_data_d;
    end
  end

  assign i2c.i2cStart           = start_q;
  assign i2c.i2cAddress         = RtcAddress;
  assign i2c.i2cNrOfBytesToSend = 8'd1;
  assign i2c.i2cByteToSend      = RtcRegPointer;
  assign i2c.i2cNrOfBytesToRead = 8'(RtcReadBytes);

  assign secondsBcd   = sec_q;
  assign minutesBcd   = min_q;
  assign hoursBcd     = hr_q;
  assign clockHalted  = ch_q;
  assign timeValid    = valid_q;
  assign updated      = upd_q;
  assign busy         = busy_q;
  assign errorTimeout = err_tmo_q;
  assign errorData    = err_data_q;
  assign stateDebug   = state_q;

endmodule

// File: tb/tb_rtc_time_reader.sv
// Self-checking bench for rtc_time_reader: behavioural I2C slave, decimal
// reference model of the DS1307 register rules, directed and random polls.
module tb_rtc_time_reader;
  import rtc_pkg::*;

  localparam int CF  = 10000;
  localparam int PMS = 500;
  localparam int TMS = 6;
  localparam int P   = CF / 1000 * PMS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic readNow = 1'b0;
  always #5 clock = ~clock;

  rtc_time_reader_if i2c ();
  logic [7:0] secondsBcd, minutesBcd, hoursBcd;
  logic       clockHalted, timeValid, updated, busy, errorTimeout, errorData;
  state_e     stateDebug;

  rtc_time_reader #(
    .ClockFrequency (CF),
    .PollPeriodMs   (PMS),
    .ReadyTimeoutMs (TMS),
    .RtcAddress     (7'h68)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .readNow      (readNow),
    .i2c          (i2c.master),
    .secondsBcd   (secondsBcd),
    .minutesBcd   (minutesBcd),
    .hoursBcd     (hoursBcd),
    .clockHalted  (clockHalted),
    .timeValid    (timeValid),
    .updated      (updated),
    .busy         (busy),
    .errorTimeout (errorTimeout),
    .errorData    (errorData),
    .stateDebug   (stateDebug)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int upd_cnt   = 0;
  int cyc;

  logic [23:0] slv_bytes   = 24'h234512;
  logic        slv_stretch = 1'b0;
  logic        slv_hold    = 1'b0;
  logic        slv_noack   = 1'b0;
  int          slv_lat     = 4;

  logic [7:0]  m_sec = 8'h00, m_min = 8'h00, m_hr = 8'h00;
  logic        m_ch = 1'b0, m_valid = 1'b0, m_terr = 1'b0, m_derr = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clock) begin
    if (i2c.i2cStart) start_cnt++;
    if (updated)      upd_cnt++;
  end

  // Behavioural I2C master: accept a start, stay busy slv_lat cycles, answer.
  initial begin
    i2c.i2cReady               = 1'b1;
    i2c.i2cClockStretchTimeout = 1'b0;
    i2c.i2cBytesRead           = 24'h0;
    forever begin
      @(negedge clock);
      if (i2c.i2cStart && !slv_noack) begin
        @(negedge clock);
        i2c.i2cReady = 1'b0;
        repeat (slv_lat) @(negedge clock);
        while (slv_hold) @(negedge clock);
        i2c.i2cBytesRead           = slv_bytes;
        i2c.i2cClockStretchTimeout = slv_stretch;
        i2c.i2cReady               = 1'b1;
      end
    end
  end

  function automatic int bcd2int(input logic [7:0] v);
    if (v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_apply(input logic [23:0] b, input logic stretch, output bit loaded);
    int sd, md, hd, f, hr;
    bit hok, ok;
    sd = bcd2int({1'b0, b[6:0]});
    md = bcd2int({1'b0, b[14:8]});
    if (!b[22]) begin
      hd  = bcd2int({2'b00, b[21:16]});
      hok = (hd >= 0) && (hd <= 23);
      hr  = hd;
    end else begin
      f   = bcd2int({3'b000, b[20:16]});
      hok = (f >= 1) && (f <= 12);
      hr  = (f % 12) + (b[21] ? 12 : 0);
    end
    ok = (sd >= 0) && (sd <= 59) && (md >= 0) && (md <= 59) && hok;
    loaded = 1'b0;
    if (stretch) begin
      m_terr = 1'b1;
      m_derr = 1'b0;
    end else begin
      m_terr = 1'b0;
      m_derr = !ok;
      if (ok) begin
        m_sec = int2bcd(sd); m_min = int2bcd(md); m_hr = int2bcd(hr);
        m_ch = b[7]; m_valid = 1'b1; loaded = 1'b1;
      end
    end
    exp_q.push_back({7'd0, m_ch, m_hr, m_min, m_sec});
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_time"}, {7'd0, clockHalted, hoursBcd, minutesBcd, secondsBcd}, e);
    check({tag, "_valid"}, timeValid, m_valid);
    check({tag, "_errd"}, errorData, m_derr);
    check({tag, "_errt"}, errorTimeout, m_terr);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string tag);
    int n = 0;
    while (busy !== lvl && n < max) begin
      @(negedge clock);
      n++;
    end
    if (busy !== lvl) check({tag, "_busywait"}, busy, lvl);
  endtask

  task automatic wait_safe();
    while (busy || (cyc % P) > P - 120 || (cyc % P) < 100) @(negedge clock);
  endtask

  task automatic pulse_read();
    @(negedge clock) readNow = 1'b1;
    @(negedge clock) readNow = 1'b0;
  endtask

  task automatic run_poll(input logic [23:0] b, input logic stretch, input string tag);
    int  u0;
    bit  loaded;
    wait_safe();
    slv_bytes = b;
    slv_stretch = stretch;
    u0 = upd_cnt;
    pulse_read();
    wait_busy(1'b1, 20, tag);
    wait_busy(1'b0, 400, tag);
    repeat (2) @(negedge clock);
    model_apply(b, stretch, loaded);
    check_outputs(tag);
    check({tag, "_upd"}, upd_cnt - u0, loaded ? 1 : 0);
    slv_stretch = 1'b0;
  endtask

  function automatic logic [23:0] rand_bytes();
    logic [7:0] s, m, h;
    if ($urandom_range(0, 3) == 0) return 24'($urandom);
    s = int2bcd($urandom_range(0, 59)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
    m = int2bcd($urandom_range(0, 59));
    if ($urandom_range(0, 1)) h = int2bcd($urandom_range(0, 23));
    else h = 8'h40 | ($urandom_range(0, 1) ? 8'h20 : 8'h00) | int2bcd($urandom_range(1, 12));
    return {h, m, s};
  endfunction

  initial begin
    int  s0, u0, n;
    bit  loaded;
    logic [23:0] last;

    repeat (3) @(negedge clock);
    check("rst_time", {hoursBcd, minutesBcd, secondsBcd}, 24'h0);
    check("rst_flags", {i2c.i2cStart, clockHalted, timeValid, updated, busy, errorTimeout, errorData}, 7'h0);
    reset = 1'b1;
    @(negedge clock);
    check("const_bus", {i2c.i2cAddress, i2c.i2cNrOfBytesToSend, i2c.i2cByteToSend, i2c.i2cNrOfBytesToRead},
          {7'h68, 8'd1, 8'h00, 8'd3});

    // Free-running timer poll with no readNow.
    while ((cyc % P) != P - 10) @(negedge clock);
    s0 = start_cnt;
    repeat (80) @(negedge clock);
    check("timer_starts", start_cnt - s0, 1);
    model_apply(slv_bytes, 1'b0, loaded);
    check_outputs("timer");

    run_poll(24'h234512, 1'b0, "main");
    run_poll(24'h713005, 1'b0, "pm11");
    run_poll(24'h521506, 1'b0, "am12");
    run_poll(24'h725907, 1'b0, "pm12");
    run_poll(24'h09008A, 1'b0, "bad_sec");
    run_poll(24'h094580, 1'b0, "ch_set");
    last = 24'h094580;
    run_poll(last, 1'b1, "stretch");
    run_poll(last, 1'b0, "after_stretch");

    // Master acknowledges but never completes.
    wait_safe();
    slv_hold = 1'b1;
    pulse_read();
    wait_busy(1'b1, 20, "hang");
    wait_busy(1'b0, 400, "hang");
    check("hang_errt", errorTimeout, 1'b1);
    check("hang_busy", busy, 1'b0);
    check("hang_time", {hoursBcd, minutesBcd, secondsBcd}, {m_hr, m_min, m_sec});
    slv_hold = 1'b0;
    run_poll(last, 1'b0, "hang_clear");

    // Master never acknowledges the start.
    wait_safe();
    slv_noack = 1'b1;
    pulse_read();
    wait_busy(1'b1, 20, "noack");
    wait_busy(1'b0, 400, "noack");
    check("noack_errt", errorTimeout, 1'b1);
    slv_noack = 1'b0;
    run_poll(last, 1'b0, "noack_clear");

    // readNow while busy, coincident with timer expiry: one queued transaction.
    while (busy || (cyc % P) != P - 40) @(negedge clock);
    slv_lat = 50;
    s0 = start_cnt;
    u0 = upd_cnt;
    readNow = 1'b1;
    @(negedge clock) readNow = 1'b0;
    while ((cyc % P) != P - 2) @(negedge clock);
    readNow = 1'b1;
    repeat (4) @(negedge clock);
    readNow = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      n++;
    end
    check("coinc_starts", start_cnt - s0, 2);
    check("coinc_upd", upd_cnt - u0, 2);
    slv_lat = 4;

    // Asynchronous reset in WaitDone.
    wait_safe();
    slv_lat = 20;
    pulse_read();
    n = 0;
    while (i2c.i2cReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("rst_mid_ack", i2c.i2cReady, 1'b0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_time", {hoursBcd, minutesBcd, secondsBcd}, 24'h0);
    check("rst_mid_flags", {i2c.i2cStart, busy, timeValid, updated, clockHalted}, 5'h0);
    @(negedge clock) reset = 1'b1;
    m_sec = 8'h00; m_min = 8'h00; m_hr = 8'h00;
    m_ch = 1'b0; m_valid = 1'b0; m_terr = 1'b0; m_derr = 1'b0;
    slv_lat = 4;
    run_poll(24'h234512, 1'b0, "post_rst");

    for (int i = 0; i < 30; i++) begin
      slv_lat = $urandom_range(1, 12);
      run_poll(rand_bytes(), 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_time_reader.md
Name: rtc_time_reader

Overview:
- Periodic DS1307-style real-time-clock poller for the clock design; sits directly upstream of the I2C master and drives its start/address/byte interface.
- Each poll writes register pointer 0x00, then reads 3 bytes (seconds, minutes, hours).
- Validates the BCD data, normalises 12h mode to 24h, and presents time registers plus status to the display logic.

Parameters:
- ClockFrequency, 1000000, system clock in Hz.
- PollPeriodMs, 250, interval between automatic polls in ms; must be >= 1.
- ReadyTimeoutMs, 50, max time waiting on each i2cReady edge before declaring timeout; must be >= 1.
- RtcAddress, 7'h68, 7-bit I2C slave address.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset (asserted when 0).
- readNow  input  1  request an immediate poll; single-cycle pulse or level.
- i2cStart  output  1  one-cycle start request to the I2C master.
- i2cAddress  output  7  always RtcAddress.
- i2cNrOfBytesToSend  output  8  constant 1.
- i2cByteToSend  output  8  constant 8'h00 (register pointer).
- i2cNrOfBytesToRead  output  8  constant 3.
- i2cBytesRead  input  24  [7:0]=first byte read (seconds), [15:8]=minutes, [23:16]=hours.
- i2cReady  input  1  master idle/done.
- i2cClockStretchTimeout  input  1  master stretch-timeout flag, valid when i2cReady=1.
- secondsBcd  output  8  00..59 BCD.
- minutesBcd  output  8  00..59 BCD.
- hoursBcd  output  8  00..23 BCD, always 24h.
- clockHalted  output  1  CH bit (seconds[7]) from the last good read.
- timeValid  output  1  set after the first good read; cleared only by reset.
- updated  output  1  one-cycle pulse when new time is loaded.
- busy  output  1  transaction in progress.
- errorTimeout  output  1  sticky; set on ready timeout or master stretch timeout; cleared at the next poll start.
- errorData  output  1  sticky; set on invalid BCD; cleared at the next poll start.

Behaviour:
- Reset values: all time outputs 8'h00; i2cStart, clockHalted, timeValid, updated, busy, errorTimeout, errorData all 0; state Idle; poll counter 0; pending flag 0. Reset mid-transaction aborts immediately; the master is reset separately.
- Poll timer: counts ClockFrequency/1000*PollPeriodMs cycles, free-running from reset, wraps to 0 on expiry, and raises pending. readNow also raises pending. Expiry and readNow in the same cycle produce a single transaction. Either event during busy sets pending, which is serviced on return to Idle (at most one queued).
- Idle: if pending and i2cReady=1, clear pending, clear both error flags, and go to Request. If i2cReady=0, stay in Idle.
- Request: i2cStart=1 for exactly this cycle; busy=1; reset the timeout counter; go to WaitAccept.
- WaitAccept: wait for i2cReady=0, then go to WaitDone. If ReadyTimeoutMs elapses first, set errorTimeout and go to Idle.
- WaitDone: wait for i2cReady=1. If i2cClockStretchTimeout=1, set errorTimeout and go to Idle. Otherwise capture i2cBytesRead and go to Decode. The timeout counter restarts on entry; on timeout, set errorTimeout and go to Idle.
- Decode (1 cycle):
  - sec = byte0 & 7F; min = byte1 & 7F.
  - hours: if byte2[6]=0, h = byte2[5:0].
  - If byte2[6]=1 (12h mode): h12 = byte2[4:0], pm = byte2[5].
    - h12=12 -> pm ? 12 : 00.
    - Otherwise pm ? BCD(h12+12) : h12. Examples: 01->13, 09->21, 10->22, 11->23.
  - Valid iff every low nibble <= 9, sec <= 59, min <= 59, h <= 23, and in 12h mode h12 is in 01..12.
  - Valid: load sec/min/h and clockHalted=byte0[7], set timeValid=1, pulse updated=1.
  - Invalid: set errorData, hold previous outputs.
  - busy=0 on return to Idle.
- Latency: updated asserts 1 cycle after i2cReady rises in WaitDone.
- All outputs are registered.

Decomposition:
- Package rtc_pkg: state enum (Idle, Request, WaitAccept, WaitDone, Decode), RtcRegPointer=8'h00, RtcReadBytes=3, BCD limit constants.
- One combinational sub-module rtc_hours_normalizer: raw hours byte in -> 24h BCD plus valid flag out.

Test Plan:
- Slave model returns {8'h23,8'h45,8'h12} (hours, minutes, seconds) -> hoursBcd=23, minutesBcd=45, secondsBcd=12, timeValid=1, one updated pulse, no errors.
- Hours byte 8'h71 (12h, PM, 11) -> hoursBcd=23. Byte 8'h52 (12h, AM, 12) -> 00. Byte 8'h72 (PM, 12) -> 12.
- Seconds byte 8'h8A -> errorData=1, outputs unchanged, timeValid unchanged. Seconds byte 8'h80 -> secondsBcd=00, clockHalted=1.
- Master holds i2cReady=0 beyond ReadyTimeoutMs -> errorTimeout=1, busy=0; next poll clears errorTimeout.
- readNow pulsed while busy and coincident with poll expiry -> exactly one extra transaction after the current one (count i2cStart pulses = 2).
- reset pulled low in WaitDone -> i2cStart=0, busy=0, all time outputs 00 asynchronously; polling resumes after release.
